lcd_frame_writer: RTL and testbench

LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

---
 rtl/lcd_frame_writer.sv | 194 +++++++++++++++++++
 tb/tb_lcd_frame_writer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_writer.sv
// HD44780 8-bit bus writer painting a two-line PC / selected-source status frame.
// Define LCD_AUTO_REFRESH_EN to repaint frames back-to-back without a start pulse.
module lcd_frame_writer #(
  parameter int POWERON_CYCLES = 750000,
  parameter int EN_CYCLES      = 12,
  parameter int SETTLE_CYCLES  = 2500,
  parameter int CLEAR_CYCLES   = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ox1,
  input  logic [3:0] ox2,
  input  logic [3:0] ox3,
  input  logic [3:0] ox4,
  input  logic [3:0] ox5,
  input  logic [3:0] ox6,
  input  logic [3:0] ox7,
  input  logic [3:0] ox8,
  input  logic [3:0] oy,
  input  logic [3:0] oz1,
  input  logic [3:0] oz2,
  input  logic [3:0] oz3,
  input  logic [3:0] oz4,
  input  logic [3:0] oz5,
  input  logic [3:0] oz6,
  input  logic [3:0] oz7,
  input  logic [3:0] oz8,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);
  typedef enum logic [2:0] {
    S_POWERON, S_INIT, S_IDLE, S_L1_ADDR, S_L1_CHAR, S_L2_ADDR, S_L2_CHAR
  } state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

  localparam int CW = 32;
  localparam logic [CW-1:0] C_PWR = CW'(POWERON_CYCLES - 1);
  localparam logic [CW-1:0] C_EN  = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] C_SET = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] C_CLR = CW'(CLEAR_CYCLES - 1);

  state_t          r_state, w_nxt_state;
  phase_t          r_ph, w_nxt_ph;
  logic [CW-1:0]   r_cnt, w_nxt_cnt, w_wait_len;
  logic [3:0]      r_idx, w_nxt_idx;
  logic            r_pend, r_done;
  logic [31:0]     r_ox, r_oz;
  logic [3:0]      r_oy;
  logic            w_auto, w_go, w_cnt_zero, w_frame_end, w_wr_state;

`ifdef LCD_AUTO_REFRESH_EN
  assign w_auto = 1'b1;
`else
  assign w_auto = 1'b0;
`endif

  assign w_go       = r_pend | start | w_auto;
  assign w_cnt_zero = (r_cnt == '0);
  // Only the clear-display command (third init write) needs the long wait.
  assign w_wait_len = (r_state == S_INIT && r_idx == 4'd2) ? C_CLR : C_SET;
  assign w_wr_state = (r_state != S_POWERON) && (r_state != S_IDLE);

  function automatic logic [7:0] hex_asc(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] line_char(input logic [7:0] c0, input logic [7:0] c1,
                                           input logic [31:0] v, input logic [3:0] k);
    logic [3:0] nib;
    nib = 4'd10 - k;
    case (k)
      4'd0:    return c0;
      4'd1:    return c1;
      4'd2:    return 8'h3D;
      4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:
               return hex_asc(v[{nib[2:0], 2'b00} +: 4]);
      default: return 8'h20;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_POWERON;
      r_ph    <= PH_SETUP;
      r_cnt   <= C_PWR;
      r_idx   <= '0;
      r_pend  <= 1'b0;
      r_done  <= 1'b0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_oz    <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_ph    <= w_nxt_ph;
      r_cnt   <= w_nxt_cnt;
      r_idx   <= w_nxt_idx;
      r_done  <= w_frame_end;
      if (r_state == S_IDLE) r_pend <= 1'b0;
      else if (start)        r_pend <= 1'b1;
      if (r_state == S_IDLE && w_go) begin
        r_ox <= {ox8, ox7, ox6, ox5, ox4, ox3, ox2, ox1};
        r_oy <= oy;
        r_oz <= {oz8, oz7, oz6, oz5, oz4, oz3, oz2, oz1};
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ph    = r_ph;
    w_nxt_cnt   = r_cnt;
    w_nxt_idx   = r_idx;
    w_frame_end = 1'b0;
    case (r_state)
      S_POWERON: begin
        if (w_cnt_zero) begin
          w_nxt_state = S_INIT;
          w_nxt_ph    = PH_SETUP;
          w_nxt_idx   = '0;
        end else w_nxt_cnt = r_cnt - 1'b1;
      end
      S_IDLE: begin
        if (w_go) begin
          w_nxt_state = S_L1_ADDR;
          w_nxt_ph    = PH_SETUP;
          w_nxt_idx   = '0;
        end
      end
      default: begin
        case (r_ph)
          PH_SETUP: begin
            w_nxt_ph  = PH_EN;
            w_nxt_cnt = C_EN;
          end
          PH_EN: begin
            if (w_cnt_zero) begin
              w_nxt_ph  = PH_WAIT;
              w_nxt_cnt = w_wait_len;
            end else w_nxt_cnt = r_cnt - 1'b1;
          end
          default: begin
            if (w_cnt_zero) begin
              w_nxt_ph  = PH_SETUP;
              w_nxt_idx = r_idx + 1'b1;
              case (r_state)
                S_INIT:    if (r_idx == 4'd3) w_nxt_state = S_IDLE;
                S_L1_ADDR: begin w_nxt_state = S_L1_CHAR; w_nxt_idx = '0; end
                S_L1_CHAR: if (r_idx == 4'd15) begin w_nxt_state = S_L2_ADDR; w_nxt_idx = '0; end
                S_L2_ADDR: begin w_nxt_state = S_L2_CHAR; w_nxt_idx = '0; end
                S_L2_CHAR: if (r_idx == 4'd15) begin w_nxt_state = S_IDLE; w_frame_end = 1'b1; end
                default: ;
              endcase
            end else w_nxt_cnt = r_cnt - 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    lcd_data   = 8'h00;
    lcd_rs     = 1'b0;
    lcd_rw     = 1'b0;
    lcd_en     = w_wr_state && (r_ph == PH_EN);
    busy       = !(r_state == S_IDLE && !(r_pend | w_auto));
    frame_done = r_done;
    case (r_state)
      S_INIT: begin
        case (r_idx[1:0])
          2'd0:    lcd_data = 8'h38;
          2'd1:    lcd_data = 8'h0C;
          2'd2:    lcd_data = 8'h01;
          default: lcd_data = 8'h06;
        endcase
      end
      S_L1_ADDR: lcd_data = 8'h80;
      S_L1_CHAR: begin
        lcd_rs   = 1'b1;
        lcd_data = line_char(8'h50, 8'h43, r_ox, r_idx);
      end
      S_L2_ADDR: lcd_data = 8'hC0;
      S_L2_CHAR: begin
        lcd_rs   = 1'b1;
        lcd_data = line_char(8'h53, hex_asc(r_oy), r_oz, r_idx);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: bus monitor decodes lcd_en pulses, model builds expected frames.
module tb_lcd_frame_writer;
  localparam int PWR = 20, EN = 2, SET = 4, CLR = 10;
  localparam int FRAME_BUDGET = 34 * (EN + SET + 1) + 60;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] ox_v = '0, oz_v = '0;
  logic [3:0]  oy_v = '0;
  logic        busy, frame_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]  lcd_data;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  lcd_frame_writer #(.POWERON_CYCLES(PWR), .EN_CYCLES(EN), .SETTLE_CYCLES(SET),
                     .CLEAR_CYCLES(CLR)) dut (
    .clk(clk), .rst_n(rst_n),
    .ox1(ox_v[3:0]), .ox2(ox_v[7:4]), .ox3(ox_v[11:8]), .ox4(ox_v[15:12]),
    .ox5(ox_v[19:16]), .ox6(ox_v[23:20]), .ox7(ox_v[27:24]), .ox8(ox_v[31:28]),
    .oy(oy_v),
    .oz1(oz_v[3:0]), .oz2(oz_v[7:4]), .oz3(oz_v[11:8]), .oz4(oz_v[15:12]),
    .oz5(oz_v[19:16]), .oz6(oz_v[23:20]), .oz7(oz_v[27:24]), .oz8(oz_v[31:28]),
    .start(start), .busy(busy), .frame_done(frame_done),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  // Each completed lcd_en pulse: data, rs, high width, low cycles before it.
  logic [7:0] q_d[$];
  logic       q_rs[$];
  int         q_w[$], q_gap[$];
  logic [8:0] exp_q[$];
  int done_cnt = 0, rw_bad = 0, busy_lo = 0, stab_bad = 0;

  initial begin : mon
    logic pen, crs;
    logic [7:0] cd;
    int hi_w, lo_w, cg;
    pen = 0; crs = 0; cd = 0; hi_w = 0; lo_w = 0; cg = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pen = 0; hi_w = 0; lo_w = 0;
      end else begin
        if (lcd_rw !== 1'b0) rw_bad++;
        if (frame_done === 1'b1) done_cnt++;
        if (busy !== 1'b1) busy_lo++;
        if (lcd_en === 1'b1) begin
          if (!pen) begin cd = lcd_data; crs = lcd_rs; cg = lo_w; hi_w = 0; end
          else if (lcd_data !== cd || lcd_rs !== crs) stab_bad++;
          hi_w++;
        end else begin
          if (pen) begin
            q_d.push_back(cd); q_rs.push_back(crs); q_w.push_back(hi_w); q_gap.push_back(cg);
            lo_w = 0;
          end
          lo_w++;
        end
        pen = (lcd_en === 1'b1);
      end
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'd48 + {4'h0, n};
    return 8'd65 + {4'h0, n} - 8'd10;
  endfunction

  function automatic void mk_frame(input logic [31:0] ox, input logic [3:0] oy, input logic [31:0] oz);
    logic [7:0] l1[16];
    logic [7:0] l2[16];
    for (int i = 0; i < 16; i++) begin l1[i] = " "; l2[i] = " "; end
    l1[0] = "P"; l1[1] = "C"; l1[2] = "=";
    l2[0] = "S"; l2[1] = hexc(oy); l2[2] = "=";
    for (int k = 0; k < 8; k++) begin
      l1[3+k] = hexc(ox[28-4*k +: 4]);
      l2[3+k] = hexc(oz[28-4*k +: 4]);
    end
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[i]});
  endfunction

  function automatic void clr_q();
    q_d.delete(); q_rs.delete(); q_w.delete(); q_gap.delete(); exp_q.delete();
  endfunction

  task automatic wait_q(input int n, input int budget, output bit ok);
    int c = 0;
    while (q_d.size() < n && c < budget) begin @(negedge clk); c++; end
    ok = (q_d.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin @(negedge clk); c++; end
    ok = (busy === 1'b0);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    logic [7:0] cmds[4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({lcd_en, lcd_rs, lcd_rw, lcd_data, frame_done, busy} !== {3'b000, 8'h00, 2'b01})
      $display("FAIL reset_outputs got en/rs/rw/data/done/busy=%b exp=%b",
               {lcd_en, lcd_rs, lcd_rw, lcd_data, frame_done, busy}, {3'b000, 8'h00, 2'b01});
    else n_pass++;
    clr_q();
    @(posedge clk); #1 rst_n = 1'b1;
    wait_q(4, PWR + 4 * (EN + CLR + 2) + 20, ok);
    n_chk++;
    if (!ok) $display("FAIL init_timeout got %0d writes exp 4", q_d.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q_d.size(); i++) begin
      int eg;
      eg = (i == 0) ? PWR + 1 : (i == 3) ? CLR + 1 : SET + 1;
      n_chk++;
      if ({q_rs[i], q_d[i]} !== {1'b0, cmds[i]})
        $display("FAIL init_cmd%0d got rs=%0b d=%02h exp rs=0 d=%02h", i, q_rs[i], q_d[i], cmds[i]);
      else n_pass++;
      n_chk++;
      if (q_w[i] != EN || q_gap[i] != eg)
        $display("FAIL init_timing%0d got w=%0d gap=%0d exp w=%0d gap=%0d", i, q_w[i], q_gap[i], EN, eg);
      else n_pass++;
    end
    wait_idle(SET + 10, ok);
    n_chk++;
    if (!ok || q_d.size() != 4)
      $display("FAIL init_idle got busy=%b writes=%0d exp busy=0 writes=4", busy, q_d.size());
    else n_pass++;
  endtask

  task automatic test_frame();
    bit ok;
    int d0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (t == 0) begin ox_v = 32'h0040_01AC; oy_v = 4'd3; oz_v = 32'hDEAD_BEEF; end
      else begin ox_v = $urandom; oy_v = 4'($urandom_range(0, 15)); oz_v = $urandom; end
      clr_q(); mk_frame(ox_v, oy_v, oz_v); d0 = done_cnt;
      pulse_start();
      wait_q(34, FRAME_BUDGET, ok);
      n_chk++;
      if (!ok) $display("FAIL frame%0d_timeout got %0d writes exp 34", t, q_d.size()); else n_pass++;
      for (int i = 0; i < 34 && i < q_d.size(); i++) begin
        n_chk++;
        if ({q_rs[i], q_d[i]} !== exp_q[i])
          $display("FAIL frame%0d_byte%0d got rs=%0b d=%02h exp rs=%0b d=%02h",
                   t, i, q_rs[i], q_d[i], exp_q[i][8], exp_q[i][7:0]);
        else n_pass++;
        if (i > 0) begin
          n_chk++;
          if (q_w[i] != EN || q_gap[i] != SET + 1)
            $display("FAIL frame%0d_timing%0d got w=%0d gap=%0d exp w=%0d gap=%0d",
                     t, i, q_w[i], q_gap[i], EN, SET + 1);
          else n_pass++;
        end
      end
      wait_idle(SET + 10, ok);
      n_chk++;
      if (!ok || done_cnt - d0 != 1)
        $display("FAIL frame%0d_done got idle=%0b pulses=%0d exp idle=1 pulses=1", t, ok, done_cnt - d0);
      else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    bit ok;
    @(negedge clk);
    ox_v = 32'h1234_5678; oy_v = 4'hA; oz_v = 32'h0BAD_F00D;
    clr_q(); mk_frame(ox_v, oy_v, oz_v); mk_frame('1, '1, '1);
    start = 1'b1;
    @(posedge clk); #1 ox_v = '1; oy_v = '1; oz_v = '1;
    @(negedge clk) start = 1'b0;
    wait_q(34, FRAME_BUDGET, ok);
    wait_idle(SET + 10, ok);
    pulse_start();
    wait_q(68, FRAME_BUDGET, ok);
    n_chk++;
    if (!ok) $display("FAIL snap_timeout got %0d writes exp 68", q_d.size()); else n_pass++;
    for (int i = 0; i < 68 && i < q_d.size(); i++) begin
      n_chk++;
      if ({q_rs[i], q_d[i]} !== exp_q[i])
        $display("FAIL snap_byte%0d got rs=%0b d=%02h exp rs=%0b d=%02h",
                 i, q_rs[i], q_d[i], exp_q[i][8], exp_q[i][7:0]);
      else n_pass++;
    end
    wait_idle(SET + 10, ok);
  endtask

  task automatic test_pending();
    bit ok;
    int d0;
    @(negedge clk);
    ox_v = $urandom; oy_v = 4'($urandom_range(0, 15)); oz_v = $urandom;
    clr_q(); mk_frame(ox_v, oy_v, oz_v); mk_frame(ox_v, oy_v, oz_v); d0 = done_cnt;
    pulse_start();
    wait_q(5, FRAME_BUDGET, ok);
    for (int p = 0; p < 3; p++) begin
      pulse_start();
      repeat ($urandom_range(3, 30)) @(negedge clk);
    end
    wait_q(68, 2 * FRAME_BUDGET, ok);
    n_chk++;
    if (!ok) $display("FAIL pend_timeout got %0d writes exp 68", q_d.size()); else n_pass++;
    for (int i = 0; i < 68 && i < q_d.size(); i++) begin
      n_chk++;
      if ({q_rs[i], q_d[i]} !== exp_q[i])
        $display("FAIL pend_byte%0d got rs=%0b d=%02h exp rs=%0b d=%02h",
                 i, q_rs[i], q_d[i], exp_q[i][8], exp_q[i][7:0]);
      else n_pass++;
    end
    wait_idle(SET + 10, ok);
    repeat (100) @(negedge clk);
    n_chk++;
    if (!ok || q_d.size() != 68 || done_cnt - d0 != 2 || busy !== 1'b0)
      $display("FAIL pend_idle got writes=%0d pulses=%0d busy=%b exp writes=68 pulses=2 busy=0",
               q_d.size(), done_cnt - d0, busy);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int c = 0;
    logic [7:0] cmds[4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
    @(negedge clk);
    ox_v = $urandom; oy_v = 4'($urandom_range(0, 15)); oz_v = $urandom;
    clr_q();
    pulse_start();
    wait_q(5, FRAME_BUDGET, ok);
    while (lcd_en !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    n_chk++;
    if (lcd_en !== 1'b1 || q_d.size() != 5)
      $display("FAIL mid_reach got en=%b writes=%0d exp en=1 writes=5", lcd_en, q_d.size());
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({lcd_en, lcd_rs, lcd_data, busy, frame_done} !== {2'b00, 8'h00, 2'b10})
      $display("FAIL mid_reset_outputs got en/rs/data/busy/done=%b exp=%b",
               {lcd_en, lcd_rs, lcd_data, busy, frame_done}, {2'b00, 8'h00, 2'b10});
    else n_pass++;
    repeat (2) @(negedge clk);
    clr_q();
    @(posedge clk); #1 rst_n = 1'b1;
    wait_q(4, PWR + 4 * (EN + CLR + 2) + 20, ok);
    n_chk++;
    if (!ok) $display("FAIL reinit_timeout got %0d writes exp 4", q_d.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q_d.size(); i++) begin
      int eg;
      eg = (i == 0) ? PWR + 1 : (i == 3) ? CLR + 1 : SET + 1;
      n_chk++;
      if ({q_rs[i], q_d[i]} !== {1'b0, cmds[i]} || q_gap[i] != eg)
        $display("FAIL reinit_cmd%0d got rs=%0b d=%02h gap=%0d exp rs=0 d=%02h gap=%0d",
                 i, q_rs[i], q_d[i], q_gap[i], cmds[i], eg);
      else n_pass++;
    end
    wait_idle(SET + 10, ok);
    n_chk++;
    if (!ok || q_d.size() != 4)
      $display("FAIL reinit_idle got busy=%b writes=%0d exp busy=0 writes=4", busy, q_d.size());
    else n_pass++;
  endtask

  task automatic test_auto_refresh();
    bit ok;
    int c = 0;
    rst_n = 1'b0;
    ox_v = $urandom; oy_v = 4'($urandom_range(0, 15)); oz_v = $urandom;
    repeat (3) @(negedge clk);
    clr_q(); mk_frame(ox_v, oy_v, oz_v); mk_frame(ox_v, oy_v, oz_v);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_q(4, PWR + 4 * (EN + CLR + 2) + 20, ok);
    n_chk++;
    if (!ok) $display("FAIL auto_init_timeout got %0d writes exp 4", q_d.size()); else n_pass++;
    done_cnt = 0; busy_lo = 0;
    while (done_cnt < 2 && c < 3 * FRAME_BUDGET) begin @(negedge clk); c++; end
    n_chk++;
    if (done_cnt != 2) $display("FAIL auto_done got %0d pulses exp 2", done_cnt); else n_pass++;
    n_chk++;
    if (busy_lo != 0) $display("FAIL auto_busy got %0d low cycles exp 0", busy_lo); else n_pass++;
    for (int i = 0; i < 68 && i + 4 < q_d.size(); i++) begin
      n_chk++;
      if ({q_rs[i+4], q_d[i+4]} !== exp_q[i])
        $display("FAIL auto_byte%0d got rs=%0b d=%02h exp rs=%0b d=%02h",
                 i, q_rs[i+4], q_d[i+4], exp_q[i][8], exp_q[i][7:0]);
      else n_pass++;
    end
  endtask

  initial begin
`ifdef LCD_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_reset();
    test_frame();
    test_snapshot();
    test_pending();
    test_reset_midframe();
`endif
    n_chk++;
    if (rw_bad != 0 || stab_bad != 0)
      $display("FAIL bus_rules got rw_high=%0d unstable=%0d exp 0 and 0", rw_bad, stab_bad);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
